niosii_sys_led_pio: RTL and testbench

Avalon-MM slave output port for the Nios II system: the CPU writes a data register whose bits drive `out_port`, typically the board LEDs. It is the write-side counterpart of the key input port. It provides atomic bit set/clear registers and an optional hardware blink engine, so software can flash LEDs without a timer ISR. Read data is registered with one-cycle latency.

---
 rtl/niosII_sys_led_pio_pkg.sv | 15 +
 rtl/niosII_sys_led_blink_timer.sv | 33 +++
 rtl/niosii_sys_led_pio.sv | 96 +++++++++
 tb/tb_niosii_sys_led_pio.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/niosII_sys_led_pio_pkg.sv
// rtl/niosII_sys_led_pio_pkg.sv - register map and default sizes for the LED output PIO
package niosII_sys_led_pio_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_RESET_VALUE = 0;
    localparam int DEF_PERIOD_W    = 24;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_OUT    = 3'd3;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLR    = 3'd5;

endpackage

// File: rtl/niosII_sys_led_blink_timer.sv
// rtl/niosII_sys_led_blink_timer.sv - half-period down-counter and blink phase bit
module niosII_sys_led_blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                load,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt;

    // A PERIOD write restarts the sequence from phase 0 and wins over the count step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (load) begin
            cnt   <= period;
            phase <= 1'b0;
        end else if (period == '0) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == '0) begin
            cnt   <= period;
            phase <= ~phase;
        end else begin
            cnt   <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/niosii_sys_led_pio.sv
// rtl/niosii_sys_led_pio.sv - Avalon-MM LED output PIO with set/clear and optional blink (LED_PIO_BLINK_EN)
module niosii_sys_led_pio
    import niosII_sys_led_pio_pkg::*;
#(
    parameter int          WIDTH       = DEF_WIDTH,
    parameter logic [31:0] RESET_VALUE = DEF_RESET_VALUE,
    parameter int          PERIOD_W    = DEF_PERIOD_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q;
    logic [31:0]      rd_mux;
    logic             unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE[WIDTH-1:0];
        end else if (wr_en) begin
            case (address)
                ADDR_DATA: data_q <= wd;
                ADDR_SET:  data_q <= data_q | wd;
                ADDR_CLR:  data_q <= data_q & ~wd;
                default:   ;
            endcase
        end
    end

`ifdef LED_PIO_BLINK_EN
    logic [WIDTH-1:0]    mask_q;
    logic [PERIOD_W-1:0] period_q;
    logic                period_load;
    logic [PERIOD_W-1:0] period_now;
    logic                phase;

    assign period_load = wr_en && (address == ADDR_PERIOD);
    // The timer sees the incoming value on the load edge so cnt reloads with it.
    assign period_now  = period_load ? writedata[PERIOD_W-1:0] : period_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q   <= '0;
            period_q <= '0;
        end else if (wr_en) begin
            if (address == ADDR_MASK)   mask_q   <= wd;
            if (address == ADDR_PERIOD) period_q <= writedata[PERIOD_W-1:0];
        end
    end

    niosII_sys_led_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_blink_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_now),
        .load    (period_load),
        .phase   (phase)
    );

    assign out_port = data_q ^ (mask_q & {WIDTH{phase}});
`else
    assign out_port = data_q;
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = data_q;
`ifdef LED_PIO_BLINK_EN
            ADDR_MASK:   rd_mux[WIDTH-1:0]    = mask_q;
            ADDR_PERIOD: rd_mux[PERIOD_W-1:0] = period_q;
`endif
            ADDR_OUT:  rd_mux[WIDTH-1:0] = out_port;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

endmodule

// File: tb/tb_niosii_sys_led_pio.sv
// tb/tb_niosii_sys_led_pio.sv - scoreboard bench for the LED output PIO
module tb_niosii_sys_led_pio;

    localparam int          WIDTH = 8;
    localparam int          PW    = 24;
    localparam logic [31:0] RV    = 32'h0000_00A5;
`ifdef LED_PIO_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    niosii_sys_led_pio #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV),
        .PERIOD_W    (PW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    // Reference model: phase derives from cycles elapsed since the last PERIOD write.
    logic [7:0]  m_data;
    logic [7:0]  m_mask;
    int unsigned m_period;
    int unsigned m_k;

    function automatic bit m_phase(input int unsigned k);
        return (m_period != 0) && (((k / (m_period + 1)) % 2) == 1);
    endfunction

    function automatic logic [7:0] m_out(input int unsigned k);
        return m_data ^ (m_mask & {8{m_phase(k)}});
    endfunction

    task automatic m_reset();
        m_data = RV[7:0]; m_mask = '0; m_period = 0; m_k = 0;
    endtask

    typedef struct {
        logic [31:0] rd;
        logic [7:0]  out;
        string       name;
    } exp_t;
    exp_t q[$];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    // One bus cycle; the expected post-edge readdata/out_port go to the scoreboard.
    task automatic cycle(input bit cs, input bit wr, input logic [2:0] a, input logic [31:0] d, input string nm);
        exp_t e;
        @(negedge clk);
        chipselect = cs; write_n = !wr; address = a; writedata = d;
        case (a)
            3'd0:    e.rd = {24'h0, m_data};
            3'd1:    e.rd = BLINK ? {24'h0, m_mask} : 32'h0;
            3'd2:    e.rd = BLINK ? m_period : 32'h0;
            3'd3:    e.rd = {24'h0, m_out(m_k)};
            default: e.rd = 32'h0;
        endcase
        if (cs && wr && BLINK && a == 3'd2) begin
            m_period = d & 32'h00FF_FFFF;
            m_k = 0;
        end else begin
            m_k++;
        end
        if (cs && wr) begin
            case (a)
                3'd0: m_data = d[7:0];
                3'd1: if (BLINK) m_mask = d[7:0];
                3'd4: m_data = m_data | d[7:0];
                3'd5: m_data = m_data & ~d[7:0];
                default: ;
            endcase
        end
        e.out  = m_out(m_k);
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input string nm);
        cycle(1'b1, 1'b1, a, d, nm);
    endtask
    task automatic rd(input logic [2:0] a, input string nm);
        cycle(1'b1, 1'b0, a, 32'hDEAD_BEEF, nm);
    endtask
    task automatic idle(input int n, input string nm);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 3'($urandom_range(0, 7)), $urandom, nm);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check({e.name, " out_port"}, {24'h0, out_port}, {24'h0, e.out});
            check({e.name, " readdata"}, readdata, e.rd);
        end
    end

    task automatic async_reset(input string nm);
        @(posedge clk);
        #3;
        chipselect = 1'b0;
        reset_n = 1'b0;
        #1;
        check({nm, " out_port"}, {24'h0, out_port}, RV);
        check({nm, " readdata"}, readdata, 32'h0);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int guard;
        logic [2:0]  a;
        logic [31:0] d;
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        m_reset();
        async_reset("reset0");
        rd(3'd3, "read_out_after_reset");

        wr(3'd0, 32'h0F, "data_0f");
        wr(3'd4, 32'h30, "outset_30");
        wr(3'd5, 32'h03, "outclear_03");
        rd(3'd4, "read_set");
        rd(3'd5, "read_clr");
        rd(3'd3, "read_out");

        wr(3'd0, 32'h00, "blink_data0");
        wr(3'd1, 32'h01, "blink_mask");
        wr(3'd2, 32'h03, "blink_period3");
        idle(12, "blink_run");
        rd(3'd2, "read_period");

        guard = 0;
        while (!m_phase(m_k) && guard < 10) begin idle(1, "wait_phase1"); guard++; end
        wr(3'd2, 32'h0, "period_to_0");
        idle(6, "period0_hold");
        rd(3'd3, "read_out_period0");

        wr(3'd1, 32'h01, "coll_mask");
        wr(3'd2, 32'h03, "coll_period");
        guard = 0;
        while (BLINK && m_phase(m_k + 1) == m_phase(m_k) && guard < 10) begin idle(1, "coll_wait"); guard++; end
        wr(3'd4, 32'h80, "collision_outset");
        idle(2, "coll_after");

        wr(3'd6, 32'hFFFF_FFFF, "wr_reserved6");
        rd(3'd6, "read_reserved6");
        rd(3'd0, "read_data_after_rsv");
        wr(3'd3, 32'h5A, "wr_out_ignored");
        wr(3'd7, 32'hFFFF_FFFF, "wr_reserved7");
        rd(3'd7, "read_reserved7");
        rd(3'd0, "read_data_after_ro");

        async_reset("reset_mid");
        rd(3'd0, "read_data_post_reset");

        for (int i = 0; i < 400; i++) begin
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd2) d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 5));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, d, "random");
        end
        idle(3, "drain");

        guard = 0;
        while (q.size() > 0 && guard < 20) begin @(negedge clk); guard++; end
        tests++;
        if (q.size() > 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
